conv_result_writer: RTL

Write-side counterpart of the convolution address controller. It accepts the stream of accumulated convolution results, one per output pixel in raster order. Each result is normalised by an arithmetic right shift and saturated to an 8-bit pixel. The block generates the filtered-image RAM write address, write enable and data, and signals frame completion.

---
 rtl/conv_result_writer.sv | 124 ++++++++++++
 1 files changed

// File: rtl/conv_result_writer.sv
// Convolution result writer: normalises, saturates and stores output
// pixels in raster order into the filtered-image RAM.
module conv_result_writer #(
  parameter int IMG_SIZE  = 256,
  parameter int KER_SIZE  = 3,
  parameter int OUT_PITCH = 256,
  parameter int ACC_W     = 20,
  parameter int SHIFT     = 4
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             start_i,
  input  logic             pix_valid_i,
  input  logic [ACC_W-1:0] pix_acc_i,
  output logic             wr_en_o,
  output logic [15:0]      wr_addr_o,
  output logic [7:0]       wr_data_o,
  output logic             busy_o,
  output logic             done_o,
  output logic [15:0]      sat_count_o
);

  localparam int OUT_W = IMG_SIZE - KER_SIZE + 1;
  localparam int SW    = ACC_W - SHIFT;
  localparam logic signed [SW-1:0] MAXV = SW'(255);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t state_q, state_d;

  logic [15:0] col_q, col_d;
  logic [15:0] row_q, row_d;
  logic [15:0] base_q, base_d;
  logic [15:0] sat_q, sat_d;
  logic [15:0] addr_q, addr_d;
  logic [7:0]  data_q, data_d;
  logic        wen_q, wen_d;

  logic signed [SW-1:0] s_w;
  logic lo_w, hi_w, acc_w;
  logic last_col_w, last_w;

  // Full-width shifted value so the clamp never sees a truncated result
  assign s_w  = pix_acc_i[ACC_W-1:SHIFT];
  assign lo_w = s_w[SW-1];
  assign hi_w = !s_w[SW-1] && (s_w > MAXV);

  assign acc_w      = (state_q == RUN) && pix_valid_i;
  assign last_col_w = (col_q == 16'(OUT_W - 1));
  assign last_w     = last_col_w && (row_q == 16'(OUT_W - 1));

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= IDLE;
      col_q   <= '0;
      row_q   <= '0;
      base_q  <= '0;
      sat_q   <= '0;
      addr_q  <= '0;
      data_q  <= '0;
      wen_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      col_q   <= col_d;
      row_q   <= row_d;
      base_q  <= base_d;
      sat_q   <= sat_d;
      addr_q  <= addr_d;
      data_q  <= data_d;
      wen_q   <= wen_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (start_i) state_d = RUN;
      RUN:     if (acc_w && last_w) state_d = DONE;
      DONE:    if (start_i) state_d = RUN;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    col_d  = col_q;
    row_d  = row_q;
    base_d = base_q;
    sat_d  = sat_q;
    addr_d = addr_q;
    data_d = data_q;
    wen_d  = 1'b0;
    if (state_q != RUN && start_i) begin
      col_d  = '0;
      row_d  = '0;
      base_d = '0;
      sat_d  = '0;
    end
    if (acc_w) begin
      wen_d  = 1'b1;
      addr_d = base_q + col_q;
      if (lo_w)      data_d = 8'd0;
      else if (hi_w) data_d = 8'd255;
      else           data_d = s_w[7:0];
      if ((lo_w || hi_w) && sat_q != 16'hFFFF)
        sat_d = sat_q + 16'd1;
      // Row base is a running sum; no multiplier
      if (last_col_w) begin
        col_d  = '0;
        row_d  = row_q + 16'd1;
        base_d = base_q + 16'(OUT_PITCH);
      end else begin
        col_d = col_q + 16'd1;
      end
    end
  end

  assign wr_en_o     = wen_q;
  assign wr_addr_o   = addr_q;
  assign wr_data_o   = data_q;
  assign busy_o      = (state_q == RUN);
  assign done_o      = (state_q == DONE);
  assign sat_count_o = sat_q;

endmodule
